regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of a register file, with a
// per-register outstanding-write scoreboard fed by the issue stage.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_reg,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rsv_valid,
  input  logic [4:0]           rsv_reg,
  output logic                 regwrite,
  output logic [4:0]           write_reg,
  output logic [DW-1:0]        write_data,
  output logic [31:0]          pending,
  output logic                 zero_err
);

  logic [2:0]    r_ptr;
  logic [2:0]    w_sel;
  logic          w_acc;
  logic [3:0]    w_idx;
  logic [4:0]    w_reg;
  logic [DW-1:0] w_data;
  logic [2:0]    w_ptr_nxt;
  logic [31:0]   w_pend_nxt;

  // Search from r_ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    w_acc = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      if (w_idx >= 4'(NREQ)) w_idx = w_idx - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!w_acc && (w_idx == 4'(i)) && req_valid[i]) begin
          w_acc = 1'b1;
          w_sel = 3'(i);
        end
      end
    end
    if (rst) w_acc = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    w_reg     = '0;
    w_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_acc && (w_sel == 3'(i));
      if (w_sel == 3'(i)) begin
        w_reg  = req_reg[5*i +: 5];
        w_data = req_data[DW*i +: DW];
      end
    end
    w_ptr_nxt = (w_sel == 3'(NREQ-1)) ? 3'd0 : w_sel + 3'd1;
  end

  // Set is applied after clear so a new producer wins over a retiring write.
  always_comb begin
    w_pend_nxt = pending;
    if (regwrite) w_pend_nxt[write_reg] = 1'b0;
    if (rsv_valid && (rsv_reg != 5'd0)) w_pend_nxt[rsv_reg] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      regwrite   <= 1'b0;
      zero_err   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      pending    <= '0;
    end else begin
      regwrite <= w_acc && (w_reg != 5'd0);
      zero_err <= w_acc && (w_reg == 5'd0);
      if (w_acc) begin
        write_reg  <= w_reg;
        write_data <= w_data;
        r_ptr      <= w_ptr_nxt;
      end
      pending <= w_pend_nxt;
    end
  end

endmodule
